// File: rtl/bench_misr.sv
// bench_misr: LFSR-fed RV32/RV64 ALU lanes compacted into an XLEN-bit MISR; signature framed out on tx.
// Optional: define BENCH_MISR_TD_MIX_EN to XOR the td input into every lane's op2 during RUN.
module bench_misr #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned LANES      = 2,
   parameter int unsigned SIG_CYCLES = 256,
   parameter logic [63:0] SEED       = 64'h1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [20:0]     td,
   output logic            busy,
   output logic            done,
   output logic            tx,
   output logic [XLEN-1:0] signature
);
   localparam int unsigned SHW     = $clog2(XLEN);
   localparam int unsigned CNT_TOP = (SIG_CYCLES > XLEN + 2) ? SIG_CYCLES : XLEN + 2;
   localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic [XLEN-1:0] step(input logic [XLEN-1:0] s);
      logic fb;
      if (XLEN == 32) fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      else            fb = s[XLEN-1] ^ s[XLEN-2] ^ s[XLEN-4] ^ s[XLEN-5];
      return {s[XLEN-2:0], fb};
   endfunction

   function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] x, input int unsigned n);
      return (n == 0) ? x : ((x << n) | (x >> (XLEN - n)));
   endfunction

   function automatic logic [XLEN-1:0] lane_seed(input int unsigned i);
      logic [XLEN-1:0] s;
      s = SEED[XLEN-1:0] ^ XLEN'(i + 1);
      return (s == '0) ? XLEN'(1) : s;
   endfunction

   function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                           input logic alt, input logic [2:0] f3, input logic w);
      logic [SHW-1:0]  sh;
      logic [31:0]     a32, b32, r32;
      logic [XLEN-1:0] r;
      sh  = b[SHW-1:0];
      a32 = a[31:0];
      b32 = b[31:0];
      r32 = '0;
      r   = '0;
      case (f3)
         3'd0: r = alt ? a - b : a + b;
         3'd1: r = a << sh;
         3'd2: r[0] = $signed(a) < $signed(b);
         3'd3: r[0] = a < b;
         3'd4: r = a ^ b;
         3'd5: if (alt) r = $unsigned($signed(a) >>> sh); else r = a >> sh;
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      // Word forms only exist for add/sub and the shifts; the rest ignore w.
      if (XLEN == 64 && w && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin
         case (f3)
            3'd0: r32 = alt ? a32 - b32 : a32 + b32;
            3'd1: r32 = a32 << b32[4:0];
            default: if (alt) r32 = $unsigned($signed(a32) >>> b32[4:0]); else r32 = a32 >> b32[4:0];
         endcase
         r = XLEN'($signed(r32));
      end
      return r;
   endfunction

   logic [2:0]      state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] lfsr   [LANES];
   logic [XLEN-1:0] s1_op1 [LANES];
   logic [XLEN-1:0] s1_op2 [LANES];
   logic            s1_alt [LANES];
   logic [2:0]      s1_f3  [LANES];
   logic            s1_w   [LANES];
   logic [XLEN-1:0] s2_res [LANES];
   logic            v1, v2;
   logic [XLEN-1:0] misr_in;
   logic [XLEN-1:0] op2_mix;
   logic [SHW-1:0]  bit_idx;

`ifdef BENCH_MISR_TD_MIX_EN
   assign op2_mix = XLEN'(td);
`else
   logic unused_td;
   assign op2_mix   = '0;
   assign unused_td = ^td;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         signature <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) lfsr[i] <= lane_seed(i);
      end else begin
         v1 <= (state == ST_RUN);
         v2 <= v1;
         if (v2) signature <= step(signature) ^ misr_in;
         case (state)
            ST_IDLE: if (start) begin
               // Reseeding on accept makes every run's signature reproducible.
               state     <= ST_RUN;
               cnt       <= '0;
               signature <= '0;
               for (int unsigned i = 0; i < LANES; i++) lfsr[i] <= lane_seed(i);
            end
            ST_RUN: begin
               for (int unsigned i = 0; i < LANES; i++) lfsr[i] <= step(lfsr[i]);
               if (cnt == CNT_W'(SIG_CYCLES - 1)) begin
                  state <= ST_DRAIN;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            end
            ST_DRAIN: if (cnt == CNT_W'(1)) begin
               state <= ST_SHIFT;
               cnt   <= '0;
            end else cnt <= cnt + 1'b1;
            ST_SHIFT: if (cnt == CNT_W'(XLEN + 1)) begin
               state <= ST_DONE;
               cnt   <= '0;
            end else cnt <= cnt + 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < LANES; i++) begin
         if (state == ST_RUN) begin
            s1_op1[i] <= lfsr[i];
            s1_op2[i] <= rotl(lfsr[i], XLEN / 2) ^ op2_mix;
            s1_alt[i] <= lfsr[i][5];
            s1_f3[i]  <= lfsr[i][4:2];
            s1_w[i]   <= lfsr[i][1];
         end
         s2_res[i] <= alu(s1_op1[i], s1_op2[i], s1_alt[i], s1_f3[i], s1_w[i]);
      end
   end

   always_comb begin
      misr_in = '0;
      for (int unsigned i = 0; i < LANES; i++) misr_in = misr_in ^ rotl(s2_res[i], i);
   end

   assign busy    = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_SHIFT);
   assign done    = (state == ST_DONE);
   assign bit_idx = SHW'(cnt - 1'b1);

   always_comb begin
      tx = 1'b1;
      if (state == ST_SHIFT) begin
         if (cnt == '0) tx = 1'b0;
         else if (cnt <= CNT_W'(XLEN)) tx = signature[bit_idx];
      end
   end
endmodule

// File: tb/tb_bench_misr.sv
// tb_bench_misr: scoreboard bench for bench_misr; several parameterisations run against a reference model.
// Honours BENCH_MISR_TD_MIX_EN in its model so either build can be checked.
module tb_bench_misr;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [5:0]  rstn, start, busy, done, tx;
   logic [20:0] td;
   logic [31:0] sig_a;
   logic [63:0] sig_b, sig_c;
   logic [2:0][63:0] dsig;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q [$];
   int          lat_q [$];

   localparam logic [63:0] SEED_C  = 64'hACE1_0F0F_1234_5671;
   // Seeds chosen so lane 0's first word decodes as sraw / subw / sltu respectively.
   localparam logic [63:0] DSEED [3] = '{64'h0000_0004_8000_0037, 64'h0000_0023_0000_0023, 64'h0000_0001_0000_000D};
   localparam logic [63:0] DEXP  [3] = '{64'hFFFF_FFFF_F800_0003, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
`ifdef BENCH_MISR_TD_MIX_EN
   localparam logic [63:0] TD_MASK = '1;
`else
   localparam logic [63:0] TD_MASK = '0;
`endif

   bench_misr #(.XLEN(32), .LANES(1), .SIG_CYCLES(4), .SEED(64'h1)) dut_a (
      .clock(clock), .reset_n(rstn[0]), .start(start[0]), .td(td),
      .busy(busy[0]), .done(done[0]), .tx(tx[0]), .signature(sig_a));
   bench_misr #(.XLEN(64), .LANES(2), .SIG_CYCLES(256), .SEED(64'h1)) dut_b (
      .clock(clock), .reset_n(rstn[1]), .start(start[1]), .td(td),
      .busy(busy[1]), .done(done[1]), .tx(tx[1]), .signature(sig_b));
   bench_misr #(.XLEN(64), .LANES(3), .SIG_CYCLES(16), .SEED(SEED_C)) dut_c (
      .clock(clock), .reset_n(rstn[2]), .start(start[2]), .td(td),
      .busy(busy[2]), .done(done[2]), .tx(tx[2]), .signature(sig_c));
   for (genvar g = 0; g < 3; g++) begin : g_dir
      bench_misr #(.XLEN(64), .LANES(1), .SIG_CYCLES(1), .SEED(DSEED[g])) dut_d (
         .clock(clock), .reset_n(rstn[3+g]), .start(start[3+g]), .td(td),
         .busy(busy[3+g]), .done(done[3+g]), .tx(tx[3+g]), .signature(dsig[g]));
   end

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sig_of(input int d);
      case (d)
         0: return {32'h0, sig_a};
         1: return sig_b;
         2: return sig_c;
         default: return dsig[d-3];
      endcase
   endfunction

   function automatic logic [63:0] m_mask(input int xl);
      return (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] m_step(input logic [63:0] s, input int xl);
      logic b;
      b = (xl == 32) ? (s[31] ^ s[21] ^ s[1] ^ s[0]) : (s[63] ^ s[62] ^ s[60] ^ s[59]);
      return ((s << 1) | {63'b0, b}) & m_mask(xl);
   endfunction

   function automatic logic [63:0] m_rotl(input logic [63:0] x, input int n, input int xl);
      logic [63:0] r;
      r = x;
      for (int k = 0; k < n; k++) r = ((r << 1) | (r >> (xl - 1))) & m_mask(xl);
      return r;
   endfunction

   function automatic logic [31:0] m_op32(input logic [31:0] a, input logic [31:0] b,
                                          input logic alt, input logic [2:0] f3, input int sh);
      int sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return (sa < sb) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (alt) begin
               sa = sa >>> sh;
               return sa;
            end
            return a >> sh;
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [63:0] m_op64(input logic [63:0] a, input logic [63:0] b,
                                          input logic alt, input logic [2:0] f3, input int sh);
      longint sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return (sa < sb) ? 64'd1 : 64'd0;
         3'd3: return (a < b) ? 64'd1 : 64'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (alt) begin
               sa = sa >>> sh;
               return sa;
            end
            return a >> sh;
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [63:0] m_alu(input logic [63:0] a, input logic [63:0] b, input logic alt,
                                         input logic [2:0] f3, input logic w, input int xl);
      logic [31:0] r32;
      if (xl == 32) return {32'h0, m_op32(a[31:0], b[31:0], alt, f3, int'(b[4:0]))};
      if (w && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin
         r32 = m_op32(a[31:0], b[31:0], alt, f3, int'(b[4:0]));
         return {{32{r32[31]}}, r32};
      end
      return m_op64(a, b, alt, f3, int'(b[5:0]));
   endfunction

   function automatic logic [63:0] m_signature(input int xl, input int lanes, input int cyc,
                                               input logic [63:0] seed, input logic [20:0] tdv);
      logic [63:0] l [8];
      logic [63:0] sig, acc, op2, mix;
      mix = {43'h0, tdv} & TD_MASK;
      sig = '0;
      for (int i = 0; i < lanes; i++) begin
         l[i] = (seed ^ 64'(i + 1)) & m_mask(xl);
         if (l[i] == 64'h0) l[i] = 64'h1;
      end
      for (int c = 0; c < cyc; c++) begin
         acc = '0;
         for (int i = 0; i < lanes; i++) begin
            op2 = m_rotl(l[i], xl / 2, xl) ^ mix;
            acc ^= m_rotl(m_alu(l[i], op2, l[i][5], l[i][4:2], l[i][1], xl), i, xl);
            l[i] = m_step(l[i], xl);
         end
         sig = m_step(sig, xl) ^ acc;
      end
      return sig;
   endfunction

   // Start a run on DUT d, push the model's expectation, then pop it when done fires.
   task automatic run_frame(input int d, input int xl, input int lanes, input int cyc,
                            input logic [63:0] seed, input logic [20:0] tdv, input string tag,
                            input bit hold, output logic [63:0] got);
      logic [65:0] frame, efr;
      logic [63:0] exp;
      int n, dcyc, lat, txbad, budget;
      td = tdv;
      exp_q.push_back(m_signature(xl, lanes, cyc, seed, tdv));
      lat_q.push_back(cyc + 2 + xl + 2 + 1);
      budget = cyc + xl + 40;
      frame = '0;
      txbad = 0;
      dcyc = 0;
      start[d] = 1'b1;
      @(negedge clock);
      if (!hold) start[d] = 1'b0;
      check({tag, ".busy_rise"}, busy[d], 1);
      n = 1;
      while (dcyc == 0 && n <= budget) begin
         if (done[d]) dcyc = n;
         else begin
            if (n >= cyc + 3 && n <= cyc + xl + 4) frame[n - cyc - 3] = tx[d];
            else if (tx[d] !== 1'b1) txbad++;
            @(negedge clock);
            n++;
         end
      end
      start[d] = 1'b0;
      exp = exp_q.pop_front();
      lat = lat_q.pop_front();
      efr = '0;
      efr[xl + 1] = 1'b1;
      for (int j = 0; j < xl; j++) efr[j + 1] = exp[j];
      check({tag, ".done_cycle"}, dcyc, lat);
      check({tag, ".signature"}, sig_of(d), exp);
      check({tag, ".frame"}, frame, efr);
      check({tag, ".tx_idle"}, txbad, 0);
      check({tag, ".tx_in_done"}, tx[d], 1);
      @(negedge clock);
      check({tag, ".done_width"}, done[d], 0);
      check({tag, ".busy_after"}, busy[d], 0);
      check({tag, ".sig_held"}, sig_of(d), exp);
      got = sig_of(d);
   endtask

   initial begin
      logic [63:0] s0, s1, s2;
      int ndone;
      rstn = '0;
      start = '0;
      td = '0;
      repeat (2) @(negedge clock);
      rstn = '1;
      @(negedge clock);
      for (int d = 0; d < 6; d++) begin
         check($sformatf("rst%0d.busy", d), busy[d], 0);
         check($sformatf("rst%0d.done", d), done[d], 0);
         check($sformatf("rst%0d.tx", d), tx[d], 1);
         check($sformatf("rst%0d.sig", d), sig_of(d), 0);
      end

      run_frame(0, 32, 1, 4, 64'h1, 21'h0, "a32", 1'b0, s0);

      // Abort during SHIFT at frame bit 10, with start asserted alongside reset.
      start[0] = 1'b1;
      @(negedge clock);
      start[0] = 1'b0;
      repeat (16) @(negedge clock);
      check("abort.busy_before", busy[0], 1);
      rstn[0] = 1'b0;
      start[0] = 1'b1;
      @(negedge clock);
      check("abort.busy", busy[0], 0);
      check("abort.tx", tx[0], 1);
      check("abort.sig", sig_of(0), 0);
      rstn[0] = 1'b1;
      start[0] = 1'b0;
      ndone = 0;
      for (int k = 0; k < 60; k++) begin
         if (done[0]) ndone++;
         @(negedge clock);
      end
      check("abort.no_done", ndone, 0);

      run_frame(1, 64, 2, 256, 64'h1, 21'h0, "b_run1", 1'b0, s0);
      run_frame(1, 64, 2, 256, 64'h1, 21'h0, "b_run2_hold", 1'b1, s1);
      check("b.repeatable", s1, s0);
      run_frame(1, 64, 2, 256, 64'h1, 21'h1, "b_td1", 1'b0, s2);
`ifdef BENCH_MISR_TD_MIX_EN
      check("b.td_changes_sig", s2 != s0, 1);
`else
      check("b.td_ignored", s2, s0);
`endif

      run_frame(2, 64, 3, 16, SEED_C, 21'h0, "c_lanes3", 1'b0, s0);

      for (int g = 0; g < 3; g++) begin
         run_frame(3 + g, 64, 1, 1, DSEED[g], 21'h0, $sformatf("dir%0d", g), 1'b0, s0);
         check($sformatf("dir%0d.alu_value", g), s0, DEXP[g]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
